fetch_stage: RTL

- Instruction-fetch stage with IF/ID pipeline buffer, directly upstream of decode and the stall/hazard unit.
- Holds the PC and drives the instruction-memory address.
- Predicts next PC by predecoding the fetched instruction and consulting a 2-bit saturating branch history table (BHT).
- Obeys the hazard unit's PC_Write, IF_ID_Write, IF_ID_flush and Wrong_prediction controls, and trains the BHT from EX resolution.

---
 rtl/fetch_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, predecode-based next-PC prediction with a
// 2-bit saturating BHT, and the IF/ID pipeline buffer feeding decode.
module fetch_stage #(
    parameter int          PC_W     = 32,
    parameter int          BHT_BITS = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PC_Write,
    input  logic            IF_ID_Write,
    input  logic            IF_ID_flush,
    input  logic            Wrong_prediction,
    input  logic [PC_W-1:0] EX_correct_target,
    input  logic            EX_branch_resolved,
    input  logic            EX_branch_taken,
    input  logic [PC_W-1:0] EX_branch_pc,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    output logic [31:0]     IF_ID_inst,
    output logic [PC_W-1:0] IF_ID_PC,
    output logic            IF_ID_pred_taken,
    output logic            IF_ID_valid
);

    localparam int BHT_N = 1 << BHT_BITS;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [PC_W-1:0]     pc;
    logic [1:0]          bht [BHT_N];

    logic [6:0]          opcode;
    logic [PC_W-1:0]     imm_b;
    logic [PC_W-1:0]     imm_j;
    logic [PC_W-1:0]     pc_plus4;
    logic [PC_W-1:0]     pred_next;
    logic                pred_taken;
    logic [BHT_BITS-1:0] fetch_idx;
    logic [BHT_BITS-1:0] train_idx;
    logic                unused_bits;

    assign imem_addr = pc;
    assign opcode    = imem_data[6:0];
    assign fetch_idx = pc[BHT_BITS+1:2];
    assign train_idx = EX_branch_pc[BHT_BITS+1:2];
    assign pc_plus4  = pc + PC_W'(4);

    // Only the index bits of the training PC matter to the BHT.
    assign unused_bits = ^{EX_branch_pc[1:0], EX_branch_pc[PC_W-1:BHT_BITS+2]};

    assign imm_b = {{(PC_W-12){imem_data[31]}}, imem_data[7], imem_data[30:25],
                    imem_data[11:8], 1'b0};
    assign imm_j = {{(PC_W-20){imem_data[31]}}, imem_data[19:12], imem_data[20],
                    imem_data[30:21], 1'b0};

    // JALR is deliberately predicted not-taken; EX redirects it.
    always_comb begin
        pred_taken = 1'b0;
        pred_next  = pc_plus4;
        if (opcode == OP_JAL) begin
            pred_taken = 1'b1;
            pred_next  = pc + imm_j;
        end else if (opcode == OP_BRANCH && bht[fetch_idx][1]) begin
            pred_taken = 1'b1;
            pred_next  = pc + imm_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (Wrong_prediction) begin
            pc <= EX_correct_target;
        end else if (PC_Write) begin
            pc <= pred_next;
        end
    end

    // A mispredict squashes the wrong-path fetch even without an explicit flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            IF_ID_inst       <= NOP_INST;
            IF_ID_PC         <= '0;
            IF_ID_pred_taken <= 1'b0;
            IF_ID_valid      <= 1'b0;
        end else if (Wrong_prediction || IF_ID_flush) begin
            IF_ID_inst       <= NOP_INST;
            IF_ID_PC         <= pc;
            IF_ID_pred_taken <= 1'b0;
            IF_ID_valid      <= 1'b0;
        end else if (IF_ID_Write) begin
            IF_ID_inst       <= imem_data;
            IF_ID_PC         <= pc;
            IF_ID_pred_taken <= pred_taken;
            IF_ID_valid      <= 1'b1;
        end
    end

    // Lookups this cycle see the pre-update counter; the trained value lands on the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (EX_branch_resolved) begin
            if (EX_branch_taken && bht[train_idx] != 2'b11) begin
                bht[train_idx] <= bht[train_idx] + 2'b01;
            end else if (!EX_branch_taken && bht[train_idx] != 2'b00) begin
                bht[train_idx] <= bht[train_idx] - 2'b01;
            end
        end
    end

endmodule
